// File: rtl/voice_mixer.sv
// voice_mixer: collects one sample per active voice per frame and outputs their floor average
module voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 8
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic [NUM_VOICES-1:0]          voice_active,
  input  logic [NUM_VOICES-1:0]          voice_done,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
  input  logic                           out_ready,
  output logic                           ready,
  output logic [SAMPLE_W-1:0]            comb_waveform,
  output logic                           busy,
  output logic                           overrun
);
  localparam int SUM_W  = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int CNT_W  = $clog2(NUM_VOICES + 1);
  localparam int STEP_W = $clog2(SUM_W + 1);

  typedef enum logic [1:0] {IDLE, DIV, OUT} state_t;
  state_t r_state, w_next;

  logic [NUM_VOICES-1:0] r_got, r_mask, w_got_base, w_mask_base, w_fmask, w_cap;
  logic [SAMPLE_W-1:0]   r_samp [NUM_VOICES];
  logic                  w_complete, w_clr, w_start, r_overrun, w_ge;
  logic [SUM_W-1:0]      r_acc, w_sum;
  logic [CNT_W-1:0]      r_cnt, w_pop;
  logic [CNT_W:0]        r_rem, w_trial;
  logic [STEP_W-1:0]     r_step;
  logic [SAMPLE_W-1:0]   r_out;

  // Frame tracking; a frame handed to the datapath is cleared so a new one can start that same edge
  always_comb begin
    w_complete  = (r_got == r_mask) && (r_mask != '0);
    w_clr       = (r_state == IDLE) && w_complete;
    w_got_base  = w_clr ? '0 : r_got;
    w_mask_base = w_clr ? '0 : r_mask;
    w_start     = (w_got_base == '0) && ((voice_done & voice_active) != '0);
    w_fmask     = w_start ? voice_active : w_mask_base;
    w_cap       = voice_done & w_fmask;
  end

  // Sum and count of the voices in the completed frame
  always_comb begin
    w_sum = '0;
    w_pop = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (r_mask[i]) begin
        w_sum = w_sum + SUM_W'(r_samp[i]);
        w_pop = w_pop + 1'b1;
      end
    end
  end

  // One restoring-division step: shift in the next dividend bit and try subtracting the count
  always_comb begin
    w_trial = {r_rem[CNT_W-1:0], r_acc[SUM_W-1]};
    w_ge    = w_trial >= {1'b0, r_cnt};
  end

  // Collector registers: capture strobes, flag repeats within a frame as overrun
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_got     <= '0;
      r_mask    <= '0;
      r_overrun <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) r_samp[i] <= '0;
    end else begin
      r_got  <= w_got_base | w_cap;
      r_mask <= w_fmask;
      if ((w_cap & w_got_base) != '0) r_overrun <= 1'b1;
      for (int i = 0; i < NUM_VOICES; i++)
        if (w_cap[i]) r_samp[i] <= voice_samples[i*SAMPLE_W +: SAMPLE_W];
    end
  end

  // Datapath state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state: DIV holds one extra cycle after the last quotient bit to register the result
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_complete) w_next = DIV;
    if (r_state == DIV && r_step == STEP_W'(SUM_W)) w_next = OUT;
    if (r_state == OUT && out_ready) w_next = IDLE;
  end

  // Divider registers; quotient bits shift into the accumulator as dividend bits shift out
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_step <= '0;
      r_out  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_complete) begin
          r_acc  <= w_sum;
          r_cnt  <= w_pop;
          r_rem  <= '0;
          r_step <= '0;
        end
        DIV: if (r_step == STEP_W'(SUM_W)) r_out <= r_acc[SAMPLE_W-1:0];
        else begin
          r_rem  <= w_ge ? w_trial - {1'b0, r_cnt} : w_trial;
          r_acc  <= {r_acc[SUM_W-2:0], w_ge};
          r_step <= r_step + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready         = r_state == OUT;
  assign busy          = r_state != IDLE;
  assign comb_waveform = r_out;
  assign overrun       = r_overrun;
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: directed checks of the voice averaging mixer
module tb_voice_mixer;
  logic        clk = 1'b0;
  logic        n_rst;
  logic [3:0]  voice_active, voice_done;
  logic [31:0] voice_samples;
  logic        out_ready, ready, busy, overrun;
  logic [7:0]  comb_waveform;
  int          checks = 0, errors = 0;

  voice_mixer dut (
    .clk(clk), .n_rst(n_rst), .voice_active(voice_active), .voice_done(voice_done),
    .voice_samples(voice_samples), .out_ready(out_ready), .ready(ready),
    .comb_waveform(comb_waveform), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [3:0] d, input logic [31:0] s);
    voice_done    = d;
    voice_samples = s;
    step();
    voice_done = '0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 40) begin
      step();
      n++;
    end
    chk(tag, n, 12);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk(tag, {ready, busy}, 2'b00);
  endtask

  initial begin
    n_rst = 1'b0; voice_active = '0; voice_done = '0; voice_samples = '0; out_ready = 1'b0;
    #12;
    chk("rst_ready", ready, 0);
    chk("rst_comb", comb_waveform, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    step();
    n_rst = 1'b1;
    step();

    voice_active = 4'b0001;
    strobe(4'b0001, 32'h0000_00C8);
    wait_ready("single_lat");
    chk("single_comb", comb_waveform, 8'hC8);
    chk("single_busy", busy, 1);
    accept("single_accept");
    chk("single_keep", comb_waveform, 8'hC8);

    voice_active = 4'b1011;
    strobe(4'b0001, 32'h0000_0030);
    strobe(4'b0010, 32'h0000_6000);
    step();
    strobe(4'b1000, 32'h9100_0000);
    wait_ready("three_lat");
    chk("three_comb", comb_waveform, 8'h60);
    accept("three_accept");

    voice_active = 4'b1111;
    strobe(4'b1111, 32'hFFFF_FFFF);
    wait_ready("ff_lat");
    chk("ff_comb", comb_waveform, 8'hFF);
    accept("ff_accept");

    strobe(4'b1111, 32'h0200_0001);
    wait_ready("floor_lat");
    chk("floor_comb", comb_waveform, 8'h00);
    accept("floor_accept");

    voice_active = 4'b0011;
    strobe(4'b0001, 32'h0000_0010);
    voice_active = 4'b0111;
    strobe(4'b0100, 32'h0080_0000);
    chk("mask_ignored_busy", busy, 0);
    strobe(4'b0010, 32'h0000_2000);
    wait_ready("mask_lat");
    chk("mask_comb", comb_waveform, 8'h18);
    chk("mask_overrun", overrun, 0);
    accept("mask_accept");

    voice_active = 4'b0001;
    strobe(4'b0001, 32'h0000_0040);
    wait_ready("bp_lat");
    for (int i = 0; i < 50; i++) begin
      if (i == 10) voice_done = 4'b0001;
      if (i == 10) voice_samples = 32'h0000_0050;
      if (i == 30) voice_done = 4'b0001;
      if (i == 30) voice_samples = 32'h0000_0058;
      step();
      voice_done = '0;
      chk("bp_hold", {ready, comb_waveform}, {1'b1, 8'h40});
    end
    chk("bp_overrun", overrun, 1);
    accept("bp_accept");
    wait_ready("bp_next_lat");
    chk("bp_next_comb", comb_waveform, 8'h58);
    accept("bp_next_accept");

    strobe(4'b0001, 32'h0000_0033);
    repeat (5) step();
    chk("mid_busy", busy, 1);
    n_rst = 1'b0;
    #1;
    chk("mid_ready", ready, 0);
    chk("mid_comb", comb_waveform, 0);
    chk("mid_busy_rst", busy, 0);
    chk("mid_overrun", overrun, 0);
    #2;
    n_rst = 1'b1;
    repeat (20) step();
    chk("mid_no_out", {ready, busy}, 2'b00);

    voice_active = 4'b0000;
    strobe(4'b0001, 32'h0000_0077);
    repeat (20) step();
    chk("inactive_no_out", {ready, busy, comb_waveform}, 10'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
